// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, BCD limits and segment decode for the mm:ss timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One up/down step of {min tens, min units, sec tens, sec units}; carry/borrow ripples in one pass.
  function automatic logic [15:0] bcd_step(input logic [15:0] c, input logic down);
    logic [15:0] r;
    logic        ripple;
    logic [3:0]  lim;
    r      = c;
    ripple = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim = (i % 2 == 1) ? TENS_MAX : UNITS_MAX;
      if (ripple) begin
        if (!down) begin
          if (c[i*4 +: 4] >= lim) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = c[i*4 +: 4] + 4'd1;
            ripple      = 1'b0;
          end
        end else begin
          if (c[i*4 +: 4] == 4'd0) r[i*4 +: 4] = lim;
          else begin
            r[i*4 +: 4] = c[i*4 +: 4] - 4'd1;
            ripple      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// rtl/btn_pulse.sv - button synchroniser, debouncer and rising-edge pulse
module btn_pulse #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync0, sync1, db;
  logic [CW-1:0] cnt;

  // A new level is accepted only after DEBOUNCE_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      pulse <= 1'b0;
      if (sync1 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db    <= sync1;
        cnt   <= '0;
        pulse <= sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_timer_sseg.sv
// rtl/updown_timer_sseg.sv - BCD mm:ss up/down timer with multiplexed seven-segment display
module updown_timer_sseg
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  parameter int SCAN_HZ      = 1000,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic [1:0] btn,
  input  logic       mode,
  output logic [3:0] an,
  output logic [6:0] ld,
  output logic       dp,
  output logic       alarm
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * 4);
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);

  logic           start_p, load_p;
  state_t         state, state_nxt;
  logic           run_mode;
  logic [PW-1:0]  presc;
  logic [15:0]    digits;
  logic [1:0]     scan_sel;
  logic [SCW-1:0] scan_cnt;
  logic           tick, do_load, do_start, count_zero, count_one;

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (.clk(clk), .rst(rst), .btn(btn[0]), .pulse(start_p));
  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load  (.clk(clk), .rst(rst), .btn(btn[1]), .pulse(load_p));

  assign count_zero = (digits == 16'h0000);
  assign count_one  = (digits == 16'h0001);
  assign tick       = (state == ST_RUN) && !start_p && (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PAUSE: begin
        if (load_p)       state_nxt = ST_IDLE;
        else if (start_p) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (start_p)                               state_nxt = ST_PAUSE;
        else if (run_mode && count_zero)           state_nxt = ST_DONE;
        else if (tick && run_mode && count_one)    state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (load_p) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alarm    = (state == ST_DONE);
    do_load  = load_p && (state != ST_RUN);
    do_start = start_p && !load_p && ((state == ST_IDLE) || (state == ST_PAUSE));
  end

  // Prescaler: cleared on start and in IDLE, held in PAUSE, free-running in DONE for the blink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_mode <= 1'b0;
      presc    <= '0;
      digits   <= '0;
    end else begin
      if (do_start || do_load) run_mode <= mode;
      if (do_start || state == ST_IDLE) presc <= '0;
      else if ((state == ST_RUN && !start_p) || state == ST_DONE)
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      if (do_load)
        digits <= {clamp_bcd(sw[7:4], TENS_MAX), clamp_bcd(sw[3:0], UNITS_MAX), 8'h00};
      else if (tick)
        digits <= bcd_step(digits, run_mode);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_sel <= 2'd0;
      an       <= 4'hF;
      ld       <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_sel <= scan_sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an <= (state == ST_DONE && presc >= PRESC_HALF) ? 4'hF : ~(4'b0001 << scan_sel);
      ld <= seg_decode(digits[{scan_sel, 2'b00} +: 4]);
      dp <= ~((scan_sel == 2'd2) &&
              ((state == ST_IDLE) || (state == ST_PAUSE) ||
               (state == ST_RUN && presc < PRESC_HALF)));
    end
  end

endmodule

// File: tb/tb_updown_timer_sseg.sv
// tb/tb_updown_timer_sseg.sv - directed self-checking bench for updown_timer_sseg
module tb_updown_timer_sseg;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [1:0] btn;
  logic       mode;
  logic [3:0] an;
  logic [6:0] ld;
  logic       dp;
  logic       alarm;

  int n_checks = 0;
  int n_fail   = 0;

  updown_timer_sseg #(
    .CLK_HZ(100), .TICK_HZ(1), .SCAN_HZ(5), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .mode(mode),
    .an(an), .ld(ld), .dp(dp), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press_load();
    btn[1] = 1'b1;
    repeat (10) @(negedge clk);
    btn[1] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_start(input state_t exp, input string tag);
    btn[0] = 1'b1;
    for (int k = 0; k < 30 && dut.state !== exp; k++) @(negedge clk);
    btn[0] = 1'b0;
    check_val(tag, 32'(dut.state), 32'(exp));
  endtask

  task automatic measure_step(input string tag, input int exp_cyc);
    logic [15:0] prev;
    int cyc;
    prev = dut.digits;
    cyc  = 0;
    while (dut.digits === prev && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_val(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic wait_digits(input logic [15:0] val, input int budget, input string tag);
    for (int k = 0; k < budget && dut.digits !== val; k++) @(negedge clk);
    check_val(tag, 32'(dut.digits), 32'(val));
  endtask

  task automatic wait_an(input logic [3:0] pat, input int budget, input string tag);
    for (int k = 0; k < budget && an !== pat; k++) @(negedge clk);
    check_val(tag, 32'(an), 32'(pat));
  endtask

  initial begin
    rst = 1'b1; sw = 8'h00; btn = 2'b00; mode = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_an", 32'(an), 32'h0F);
    check_val("rst_ld", 32'(ld), 32'h7F);
    check_val("rst_dp", 32'(dp), 32'h1);
    check_val("rst_alarm", 32'(alarm), 32'h0);
    check_val("rst_count", 32'(dut.digits), 32'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Load and clamp
    sw = 8'h12; mode = 1'b1;
    press_load();
    check_val("load_12", 32'(dut.digits), 32'h1200);
    sw = 8'h7C;
    press_load();
    check_val("load_clamp", 32'(dut.digits), 32'h5900);
    check_val("load_state", 32'(dut.state), 32'(ST_IDLE));
    wait_an(4'b1011, 40, "disp_d2_an");
    check_val("disp_d2_ld", 32'(ld), 32'h10);
    check_val("disp_d2_dp", 32'(dp), 32'h0);
    wait_an(4'b0111, 40, "disp_d3_an");
    check_val("disp_d3_ld", 32'(ld), 32'h12);
    check_val("disp_d3_dp", 32'(dp), 32'h1);
    wait_an(4'b1110, 40, "disp_d0_an");
    check_val("disp_d0_ld", 32'(ld), 32'h40);

    // Count up, first step latency, 59:59 wrap
    sw = 8'h00; mode = 1'b0;
    press_load();
    push_start(ST_RUN, "up_start");
    measure_step("up_first_step", 100);
    check_val("up_0001", 32'(dut.digits), 32'h0001);
    repeat (12) @(negedge clk);
    push_start(ST_PAUSE, "up_pause");
    sw = 8'h59;
    press_load();
    push_start(ST_RUN, "wrap_start");
    wait_digits(16'h5959, 6500, "reach_5959");
    measure_step("wrap_step", 100);
    check_val("wrap_0000", 32'(dut.digits), 32'h0000);
    check_val("wrap_run", 32'(dut.state), 32'(ST_RUN));

    // Count down to DONE, blink
    repeat (12) @(negedge clk);
    push_start(ST_PAUSE, "dn_pause");
    sw = 8'h01; mode = 1'b1;
    press_load();
    push_start(ST_RUN, "dn_start");
    measure_step("dn_first_step", 100);
    check_val("dn_0059", 32'(dut.digits), 32'h0059);
    wait_digits(16'h0001, 6000, "reach_0001");
    measure_step("dn_last_step", 100);
    check_val("done_0000", 32'(dut.digits), 32'h0000);
    check_val("done_state", 32'(dut.state), 32'(ST_DONE));
    check_val("done_alarm", 32'(alarm), 32'h1);
    wait_an(4'hF, 120, "blink_off");
    wait_an(4'b1110, 120, "blink_on");
    check_val("blink_ld", 32'(ld), 32'h40);

    // Down start at 00:00
    sw = 8'h00; mode = 1'b1;
    press_load();
    check_val("zero_idle", 32'(dut.state), 32'(ST_IDLE));
    check_val("zero_alarm", 32'(alarm), 32'h0);
    push_start(ST_RUN, "zero_start");
    @(negedge clk);
    check_val("zero_done", 32'(dut.state), 32'(ST_DONE));
    check_val("zero_count", 32'(dut.digits), 32'h0000);

    // Pause/resume
    sw = 8'h00; mode = 1'b0;
    press_load();
    push_start(ST_RUN, "pr_start");
    wait_digits(16'h0005, 700, "reach_0005");
    repeat (3) @(negedge clk);
    push_start(ST_PAUSE, "pr_pause");
    repeat (300) @(negedge clk);
    check_val("pr_hold", 32'(dut.digits), 32'h0005);
    check_val("pr_state", 32'(dut.state), 32'(ST_PAUSE));
    push_start(ST_RUN, "pr_resume");
    measure_step("pr_step", 100);
    check_val("pr_0006", 32'(dut.digits), 32'h0006);

    // Bounce rejection and load+start collision in PAUSE
    repeat (12) @(negedge clk);
    push_start(ST_PAUSE, "bn_pause");
    repeat (12) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      btn[0] = 1'b1;
      repeat (3) @(negedge clk);
      btn[0] = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_val("bounce_state", 32'(dut.state), 32'(ST_PAUSE));
    sw = 8'h34;
    btn = 2'b11;
    repeat (10) @(negedge clk);
    btn = 2'b00;
    repeat (10) @(negedge clk);
    check_val("both_state", 32'(dut.state), 32'(ST_IDLE));
    check_val("both_count", 32'(dut.digits), 32'h3400);

    // Reset mid-RUN
    mode = 1'b0;
    push_start(ST_RUN, "mr_start");
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mr_an", 32'(an), 32'h0F);
    check_val("mr_ld", 32'(ld), 32'h7F);
    check_val("mr_dp", 32'(dp), 32'h1);
    check_val("mr_alarm", 32'(alarm), 32'h0);
    check_val("mr_count", 32'(dut.digits), 32'h0000);
    check_val("mr_state", 32'(dut.state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
